wb_rsp_fifo: RTL

- Buffers 34-bit response words from the Wishbone master's return channel (o_rsp_stb/o_rsp_word) before they reach the UART coder.
- The master gives no backpressure, and the coder takes one word per strobe and stays busy while it serialises that word.
- The block absorbs response bursts and meters them out one strobe per coder-idle window.
- An overflow is counted as a sticky flag; it never stalls the bus.

---
 rtl/wb_bridge_pkg.sv | 30 +++
 rtl/wb_rsp_fifo_mem.sv | 34 +++
 rtl/wb_rsp_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bridge_pkg
// Description : Types and constants shared by the Wishbone bridge master,
//               the response FIFO and the UART coder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bridge_pkg;

    // Response word: 2-bit tag in the top bits, 32-bit data below
    localparam int unsigned RSP_W = 34;

    typedef logic [RSP_W-1:0] rsp_word_t;

    // Response tags carried in rsp_word_t[33:32]
    localparam logic [1:0] RSP_TAG_WR_ACK  = 2'b00;
    localparam logic [1:0] RSP_TAG_RD_DATA = 2'b01;
    localparam logic [1:0] RSP_TAG_BUS_ERR = 2'b10;
    localparam logic [1:0] RSP_TAG_RESET   = 2'b11;

    // Pop sequencer states of the response FIFO
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STB       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } pop_state_t;

endpackage : wb_bridge_pkg
`default_nettype wire

// File: rtl/wb_rsp_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : wb_rsp_fifo_mem
// Description : 1-write / 1-read register array for the response FIFO.
//               Synchronous write, combinational read, no reset on storage.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rsp_fifo_mem #(
    parameter int unsigned DW = 34,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [0:DEPTH-1];

    // Store the pushed word; contents need no reset because fill gates reads
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : wb_rsp_fifo_mem
`default_nettype wire

// File: rtl/wb_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_rsp_fifo
// Description : Response buffer between the Wishbone master return channel
//               and the UART coder. Absorbs bursts without backpressure and
//               meters words out one strobe per coder-idle window. Dropped
//               pushes raise a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rsp_fifo
    import wb_bridge_pkg::*;
#(
    parameter int unsigned DW      = RSP_W,
    parameter int unsigned AW      = 4,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wr_stb,
    input  logic [DW-1:0] i_wr_word,
    output logic          o_rd_stb,
    output logic [DW-1:0] o_rd_word,
    input  logic          i_rd_busy,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_fill,
    output logic          o_overflow,
    input  logic          i_clr_overflow
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW:0] FILL_MAX  = (AW+1)'(DEPTH);
    // Holdoff counter runs 0..HOLDOFF-1 (HOLDOFF must be at least 1)
    localparam int unsigned HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;
    logic [AW:0]   fill_d;
    logic          empty_q;
    logic          full_q;
    logic          overflow_q;

    pop_state_t    state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          rd_stb_q;
    logic [DW-1:0] rd_word_q;

    logic [DW-1:0] mem_rdata;
    logic          pop;
    logic          push_ok;
    logic          push_drop;

    // A pop needs a stored word, so a push into an empty FIFO is never
    // read through in the same cycle.
    assign pop       = (state_q == IDLE) && !empty_q && !i_rd_busy;
    // A full FIFO still accepts a push when a pop frees a slot at the same edge
    assign push_ok   = i_wr_stb && (!full_q || pop);
    assign push_drop = i_wr_stb && !push_ok;

    wb_rsp_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk_i   (i_clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        fill_d = fill_q;
        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Pointers, occupancy, registered flags and sticky overflow
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fill_q  <= fill_d;
            empty_q <= (fill_d == '0);
            full_q  <= (fill_d == FILL_MAX);
            // A new drop outranks a clear in the same cycle
            if (push_drop) begin
                overflow_q <= 1'b1;
            end else if (i_clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Pop sequencer: one strobe, then wait for the coder to go busy and idle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rd_stb_q   <= 1'b0;
            rd_word_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q   <= STB;
                        rd_stb_q  <= 1'b1;
                        rd_word_q <= mem_rdata;
                    end
                end
                STB: begin
                    state_q    <= WAIT_BUSY;
                    rd_stb_q   <= 1'b0;
                    hold_cnt_q <= '0;
                end
                WAIT_BUSY: begin
                    // A coder that never raises busy is treated as done
                    // after HOLDOFF cycles
                    if (i_rd_busy) begin
                        state_q <= WAIT_IDLE;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (!i_rd_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rd_stb_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_stb   = rd_stb_q;
    assign o_rd_word  = rd_word_q;
    assign o_empty    = empty_q;
    assign o_full     = full_q;
    assign o_fill     = fill_q;
    assign o_overflow = overflow_q;

endmodule : wb_rsp_fifo
`default_nettype wire
